scrypt_romix: RTL and testbench
===============================

# scrypt_romix

Sequential-memory-hard core of scrypt (ROMix, r=1, 1024-bit block). Takes a 1024-bit block X from the PBKDF2 front end and fills an internal N-entry scratchpad V. It then runs N data-dependent mix passes and returns the final X. It drives `scrypt_blockmix` through a request/done handshake, sitting directly upstream of it, and contains no Salsa logic of its own.

## Interface
- `N`, 1024: scratchpad depth and iteration count; power of two, 2 ≤ N ≤ 65536.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: one-cycle request; accepted only when idle.
- `data_in`  in  1024: input block X0, sampled on the accepting edge; word i at `[32*i +: 32]`.
- `data_out`  out  1024: result block, valid from the `done` cycle until the next accept.
- `busy`  out  1: high from the cycle after accept through the `done` cycle.
- `done`  out  1: one-cycle completion pulse.
- `bm_enable`  out  1: one-cycle pulse that starts a blockmix.
- `bm_data`  out  1024: blockmix input, held stable from `bm_enable` until `bm_done`.
- `bm_hash`  in  1024: blockmix result, sampled when `bm_done` is high.
- `bm_done`  in  1: blockmix completion; must arrive ≥1 cycle after `bm_enable`.

## Operation
- Registers:
  - X (1024 b).
  - Loop counter k, width log2(N)+1.
  - Scratchpad V[N] × 1024 b, synchronous write and synchronous 1-cycle read, no reset.
- FSM states: IDLE, FILL, WAIT_F, MIX_RD, MIX_XOR, WAIT_M, DONE.
- IDLE:
  - On `start`: X←`data_in`, k←0, go to FILL.
  - `start` in any other state is ignored (no queueing).
- FILL: V[k]←X; `bm_enable`=1; `bm_data`←X; go to WAIT_F.
- WAIT_F, on `bm_done`: X←`bm_hash`.
  - If k==N−1: k←0, go to MIX_RD.
  - Otherwise: k←k+1, go to FILL.
- MIX_RD: j = X[512 +: log2(N)] (word 16 mod N, the Integerify of the last 64-byte sub-block); issue read of V[j].
- MIX_XOR: `bm_data`←X ^ V[j]; `bm_enable`=1; go to WAIT_M.
- WAIT_M, on `bm_done`: X←`bm_hash`.
  - If k==N−1: go to DONE.
  - Otherwise: k←k+1, go to MIX_RD.
- DONE: `data_out`←X; `done`=1; go to IDLE.
- Exactly 2N blockmix calls per job. `bm_done` outside WAIT_F/WAIT_M is ignored.

## Timing
- Reset values: state IDLE; `busy`, `done`, `bm_enable` = 0; `data_out`, `bm_data` = 0; X = 0; k = 0.
- Reset mid-job aborts immediately. V contents are undefined afterwards. The next `start` runs a full job with no residue.
- With blockmix latency L (`bm_done` high L cycles after the `bm_enable` cycle):
  - Fill iteration: L+1 cycles.
  - Mix iteration: L+2 cycles.
  - `done` asserts 1 + N(L+1) + N(L+2) cycles after the accepting edge.
- `start` coinciding with `done`: ignored, because the FSM is not yet IDLE. `start` is accepted on the following cycle.
- `bm_enable` is never high on two consecutive cycles. `bm_data` changes only in FILL and MIX_XOR.

## Configuration
- `SCRYPT_ROMIX_CYCLE_COUNT_EN` defined:
  - Adds `cycle_count out 32`, reset 0.
  - Cleared on accept; increments every cycle while `busy`; saturates at 2^32−1; holds after `done`.
- Macro undefined: the port and counter are absent. Functional behaviour is otherwise identical.

## Test plan
- **Reset:** assert `rst` asynchronously mid-clock → all outputs 0 before the next edge; `start` 2 cycles after release is accepted.
- **Identity stub (`bm_hash`=`bm_data`, L=3), N=4, X0 word i = i:**
  - `done` at cycle 37 after accept.
  - `data_out` = X0 (mix alternates X0/0 over an even count).
  - Exactly 8 `bm_enable` pulses.
- **Increment stub (each word +1, L=1), N=4, X0 word i = i:** `data_out` matches a software ROMix model using the same stub; j sequence checked via scratchpad read addresses.
- **Busy rejection:** `start` pulsed with a different `data_in` while `busy` → ignored; result equals the first job; `start` on the `done` cycle is not accepted.
- **Reset at WAIT_M of the 3rd mix pass:** all outputs return to 0 and no `bm_enable` follows; a new job with X0=all-ones completes correctly.
- **Counter (macro defined):** identity stub, N=4, L=3 → `cycle_count` = 37 at `done` and holds afterwards.

Source files
------------

// File: rtl/scrypt_romix.sv
// -----------------------------------------------------------------------------
// scrypt_romix -- sequential-memory-hard core of scrypt (ROMix, r=1, 1024-bit).
//
// Fills an N-entry scratchpad V with successive blockmix outputs, then performs
// N data-dependent mix passes (X <- BlockMix(X ^ V[Integerify(X) mod N])) and
// returns the final X. The Salsa/BlockMix function lives in scrypt_blockmix,
// which this block drives over a one-cycle request / done handshake.
//
// Parameters:
//   N            scratchpad depth and iteration count (power of two, 2..65536)
//
// Ports:
//   clk          in   1     rising-edge clock
//   rst          in   1     asynchronous active-high reset
//   start        in   1     job request, accepted only when idle
//   data_in      in   1024  input block X0 (word i at [32*i +: 32])
//   data_out     out  1024  result block, valid from done until next accept
//   busy         out  1     high from the cycle after accept through done
//   done         out  1     one-cycle completion pulse
//   bm_enable    out  1     one-cycle blockmix start pulse
//   bm_data      out  1024  blockmix input, stable from bm_enable to bm_done
//   bm_hash      in   1024  blockmix result, sampled while bm_done is high
//   bm_done      in   1     blockmix completion
//   cycle_count  out  32    busy-cycle counter (only with the macro below)
//
// Build option:
//   SCRYPT_ROMIX_CYCLE_COUNT_EN  adds the saturating cycle_count output.
// -----------------------------------------------------------------------------
module scrypt_romix #(
  parameter int N = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1023:0] data_in,
  output logic [1023:0] data_out,
  output logic          busy,
  output logic          done,
  output logic          bm_enable,
  output logic [1023:0] bm_data,
  input  logic [1023:0] bm_hash,
  input  logic          bm_done
`ifdef SCRYPT_ROMIX_CYCLE_COUNT_EN
  ,
  output logic [31:0]   cycle_count
`endif
);

  localparam int AW = $clog2(N);
  localparam logic [AW:0] K_LAST = (AW+1)'(N - 1);

  typedef enum logic [2:0] {
    IDLE, FILL, WAIT_F, MIX_RD, MIX_XOR, WAIT_M, DONE
  } state_t;

  state_t          state_q, state_d;
  logic [1023:0]   x_q, x_d;
  logic [AW:0]     k_q, k_d;
  logic [1023:0]   bmd_q, bmd_d;
  logic [1023:0]   dout_q, dout_d;
  logic            v_we, v_re;
  logic [1023:0]   v_mem [N];
  logic [1023:0]   vrd_q;
  logic [AW-1:0]   j_idx;

  // Integerify: low bits of word 16 (first word of the last 64-byte sub-block).
  assign j_idx = x_q[512 +: AW];

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    k_d       = k_q;
    bmd_d     = bmd_q;
    dout_d    = dout_q;
    bm_enable = 1'b0;
    done      = 1'b0;
    v_we      = 1'b0;
    v_re      = 1'b0;
    // bm_data is driven live in FILL/MIX_XOR so it is valid in the same cycle
    // as bm_enable; bmd_q then holds it until the blockmix completes.
    bm_data   = bmd_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = data_in;
          k_d     = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        v_we      = 1'b1;
        bm_enable = 1'b1;
        bm_data   = x_q;
        bmd_d     = x_q;
        state_d   = WAIT_F;
      end
      WAIT_F: begin
        if (bm_done) begin
          x_d = bm_hash;
          if (k_q == K_LAST) begin
            k_d     = '0;
            state_d = MIX_RD;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = FILL;
          end
        end
      end
      MIX_RD: begin
        v_re    = 1'b1;
        state_d = MIX_XOR;
      end
      MIX_XOR: begin
        bm_enable = 1'b1;
        bm_data   = x_q ^ vrd_q;
        bmd_d     = x_q ^ vrd_q;
        state_d   = WAIT_M;
      end
      WAIT_M: begin
        if (bm_done) begin
          x_d = bm_hash;
          if (k_q == K_LAST) begin
            // Loaded on entry so data_out is already valid in the done cycle.
            dout_d  = bm_hash;
            state_d = DONE;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = MIX_RD;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign data_out = dout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      k_q     <= '0;
      bmd_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      k_q     <= k_d;
      bmd_q   <= bmd_d;
      dout_q  <= dout_d;
    end
  end

  // Scratchpad: plain synchronous RAM, no reset, one-cycle read latency.
  always_ff @(posedge clk) begin
    if (v_we) v_mem[k_q[AW-1:0]] <= x_q;
    if (v_re) vrd_q <= v_mem[j_idx];
  end

`ifdef SCRYPT_ROMIX_CYCLE_COUNT_EN
  logic [31:0] cnt_q, cnt_d;

  // The register always includes the busy cycle about to begin, so the value
  // seen during the done cycle is the full busy-cycle total for the job.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && start) begin
      cnt_d = 32'd1;
    end else if (busy && state_d != IDLE && cnt_q != 32'hFFFF_FFFF) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cycle_count = cnt_q;
`endif

endmodule

// File: tb/tb_scrypt_romix.sv
// -----------------------------------------------------------------------------
// tb_scrypt_romix -- scoreboard bench for scrypt_romix (N=4).
// A behavioural blockmix stub (identity or per-word +1, latency L) answers the
// DUT. Each job pushes its expected bm_data sequence, result and latency into
// queues; a monitor pops and compares whenever the DUT presents bm_enable/done.
// -----------------------------------------------------------------------------
module tb_scrypt_romix;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1023:0] data_in = '0;
  logic [1023:0] data_out;
  logic          busy, done, bm_enable;
  logic [1023:0] bm_data;
  logic [1023:0] bm_hash = '0;
  logic          bm_done = 1'b0;
`ifdef SCRYPT_ROMIX_CYCLE_COUNT_EN
  logic [31:0]   cycle_count;
`endif

  always #5 clk = ~clk;

  scrypt_romix #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_in   (data_in),
    .data_out  (data_out),
    .busy      (busy),
    .done      (done),
    .bm_enable (bm_enable),
    .bm_data   (bm_data),
    .bm_hash   (bm_hash),
    .bm_done   (bm_done)
`ifdef SCRYPT_ROMIX_CYCLE_COUNT_EN
    ,
    .cycle_count (cycle_count)
`endif
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk_vec(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (low 128 bits)", name, act[127:0], exp[127:0]);
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    total_cnt++;
    $display("FAIL %s: event not expected / not seen", name);
  endtask

  function automatic logic [1023:0] stub_f(input logic [1023:0] x, input bit inc);
    logic [1023:0] r;
    r = x;
    if (inc) for (int w = 0; w < 32; w++) r[32*w +: 32] = x[32*w +: 32] + 32'd1;
    return r;
  endfunction

  // ---------------- blockmix stub ----------------
  bit            stub_inc = 1'b0;
  int            stub_lat = 3;
  logic [1023:0] stub_res;

  initial forever begin
    @(negedge clk);
    if (bm_enable && !rst) begin
      stub_res = stub_f(bm_data, stub_inc);
      repeat (stub_lat) @(posedge clk);
      #1;
      bm_hash = stub_res;
      bm_done = 1'b1;
      @(posedge clk);
      #1;
      bm_done = 1'b0;
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [1023:0] exp_bm[$];
  logic [1023:0] exp_out[$];
  int            exp_lat[$];

  task automatic push_model(input logic [1023:0] x0, input bit inc, input int lat);
    logic [1023:0] x, t;
    logic [1023:0] v [N];
    logic [31:0]   w16;
    int            j;
    x = x0;
    for (int i = 0; i < N; i++) begin
      v[i] = x;
      exp_bm.push_back(x);
      x = stub_f(x, inc);
    end
    for (int i = 0; i < N; i++) begin
      w16 = x[512 +: 32];
      j = int'(w16 % 32'(N));
      t = x ^ v[j];
      exp_bm.push_back(t);
      x = stub_f(t, inc);
    end
    exp_out.push_back(x);
    exp_lat.push_back(1 + N*(lat+1) + N*(lat+2));
  endtask

  // ---------------- monitor ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int acc_cyc = 0;
  int en_cnt = 0;
  int jobs_done = 0;
  bit prev_en = 1'b0;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_en = 1'b0;
    end else begin
      if (bm_enable) begin
        en_cnt++;
        chk_int("bm_enable_back_to_back", int'(prev_en), 0);
        if (exp_bm.size() == 0) fail_now("unexpected_bm_enable");
        else chk_vec("bm_data", bm_data, exp_bm.pop_front());
      end
      prev_en = bm_enable;
      if (done) begin
        if (exp_out.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          chk_vec("data_out", data_out, exp_out.pop_front());
          chk_int("done_latency", cyc - acc_cyc + 1, exp_lat[0]);
`ifdef SCRYPT_ROMIX_CYCLE_COUNT_EN
          chk_int("cycle_count_at_done", int'(cycle_count), exp_lat[0]);
`endif
          void'(exp_lat.pop_front());
        end
        jobs_done++;
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic accept_job(input logic [1023:0] x0, input bit inc, input int lat);
    stub_inc = inc;
    stub_lat = lat;
    en_cnt   = 0;
    push_model(x0, inc, lat);
    @(negedge clk);
    start   = 1'b1;
    data_in = x0;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    start   = 1'b0;
  endtask

  task automatic wait_done();
    int tgt;
    tgt = jobs_done + 1;
    for (int i = 0; i < 500 && jobs_done < tgt; i++) @(posedge clk);
    if (jobs_done < tgt) fail_now("done_timeout");
  endtask

  task automatic run_job(input logic [1023:0] x0, input bit inc, input int lat);
    accept_job(x0, inc, lat);
    wait_done();
    @(negedge clk);
    chk_int("bm_enable_count", en_cnt, 2*N);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk_int({tag, "_busy"}, int'(busy), 0);
    chk_int({tag, "_done"}, int'(done), 0);
    chk_int({tag, "_bm_enable"}, int'(bm_enable), 0);
    chk_vec({tag, "_data_out"}, data_out, '0);
    chk_vec({tag, "_bm_data"}, bm_data, '0);
`ifdef SCRYPT_ROMIX_CYCLE_COUNT_EN
    chk_int({tag, "_cycle_count"}, int'(cycle_count), 0);
`endif
  endtask

  // ---------------- stimulus ----------------
  logic [1023:0] x_ramp, x_alt, x_ones;
  bit            seen;

  initial begin
    for (int i = 0; i < 32; i++) begin
      x_ramp[32*i +: 32] = 32'(i);
      x_alt[32*i +: 32]  = 32'hA500_0000 + 32'(i * 3);
    end
    x_ones = '1;

    // Power-on reset, then start two cycles after release.
    repeat (3) @(posedge clk);
    #2;
    chk_outputs_zero("por");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);

    // Identity stub, L=3: result equals X0, 37-cycle latency, 8 calls.
    run_job(x_ramp, 1'b0, 3);
    chk_vec("identity_out_is_x0", data_out, x_ramp);
`ifdef SCRYPT_ROMIX_CYCLE_COUNT_EN
    repeat (3) @(negedge clk);
    chk_int("cycle_count_hold", int'(cycle_count), 37);
`endif

    // Increment stub, L=1.
    run_job(x_ramp, 1'b1, 1);

    // Busy rejection: start while busy and on the done cycle are ignored.
    accept_job(x_alt, 1'b0, 3);
    repeat (5) @(negedge clk);
    start   = 1'b1;
    data_in = ~x_alt;
    @(posedge clk);
    #1;
    start = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) fail_now("busy_job_done_timeout");
    start   = 1'b1;
    data_in = ~x_alt;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk_int("start_on_done_ignored", int'(busy), 0);
    chk_int("busy_job_enable_count", en_cnt, 2*N);
    repeat (10) @(negedge clk);
    chk_vec("busy_job_out_hold", data_out, x_alt);

    // Asynchronous reset during WAIT_M of the third mix pass.
    accept_job(x_ramp, 1'b0, 3);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (en_cnt >= N + 3) seen = 1'b1;
    end
    if (!seen) fail_now("third_mix_timeout");
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_outputs_zero("midjob_rst");
    exp_bm.delete();
    exp_out.delete();
    exp_lat.delete();
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    en_cnt = 0;
    repeat (10) @(negedge clk);
    chk_int("no_enable_after_reset", en_cnt, 0);

    // Fresh job after the abort: all-ones input, increment stub.
    run_job(x_ones, 1'b1, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
